// File: rtl/pkt_gen_pkg.sv
// Shared state type, frame-layout constants and helpers for the 250 MHz
// Ethernet/IPv4/UDP synthetic frame generator.
package pkt_gen_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FRAME,
    GAP,
    DONE
  } state_t;

  localparam int ETH_HDR_LEN  = 14;
  localparam int IPV4_HDR_LEN = 20;
  localparam int UDP_HDR_LEN  = 8;
  localparam int HDR_LEN      = ETH_HDR_LEN + IPV4_HDR_LEN + UDP_HDR_LEN;
  localparam int MIN_LEN      = 64;
  localparam int MAX_LEN      = 9600;

  localparam logic [15:0] ETYPE_IPV4 = 16'h0800;

  // Per-run header fields captured at cfg_start.
  typedef struct packed {
    logic [47:0] mac_dst;
    logic [47:0] mac_src;
    logic [31:0] ip_src;
    logic [31:0] ip_dst;
    logic [15:0] l4_src;
    logic [15:0] l4_dst;
    logic [7:0]  ip_proto;
  } hdr_cfg_t;

  // Ones-complement checksum over ten 16-bit IPv4 header words (checksum word = 0).
  function automatic logic [15:0] ipv4_csum(input logic [159:0] hw);
    logic [19:0] sum;
    sum = '0;
    for (int k = 0; k < 10; k++) begin
      sum = sum + {4'h0, hw[16*k +: 16]};
    end
    sum = {4'h0, sum[15:0]} + {16'h0000, sum[19:16]};
    sum = {4'h0, sum[15:0]} + {16'h0000, sum[19:16]};
    return ~sum[15:0];
  endfunction

  function automatic logic [15:0] clamp_len(input logic [15:0] len);
    if (len < 16'(MIN_LEN)) begin
      return 16'(MIN_LEN);
    end else if (len > 16'(MAX_LEN)) begin
      return 16'(MAX_LEN);
    end else begin
      return len;
    end
  endfunction

endpackage

// File: rtl/pkt_gen_hdr.sv
// Combinational builder for the 42-byte Ethernet/IPv4/UDP header; byte k of
// the frame lands in hdr_bytes[8k+7:8k].
module pkt_gen_hdr
  import pkt_gen_pkg::*;
(
  input  hdr_cfg_t                cfg,
  input  logic [15:0]             ip_id,
  input  logic [15:0]             len,
  output logic [HDR_LEN*8-1:0]    hdr_bytes
);

  logic [15:0]          ip_tot_len;
  logic [15:0]          udp_len;
  logic [15:0]          csum;
  logic [HDR_LEN*8-1:0] hdr_be;

  assign ip_tot_len = len - 16'(ETH_HDR_LEN);
  assign udp_len    = len - 16'(ETH_HDR_LEN + IPV4_HDR_LEN);

  assign csum = ipv4_csum({8'h45, 8'h00, ip_tot_len, ip_id, 16'h0000,
                           8'd64, cfg.ip_proto, 16'h0000, cfg.ip_src, cfg.ip_dst});

  // Network order: the first frame byte is the most significant byte here.
  assign hdr_be = {cfg.mac_dst, cfg.mac_src, ETYPE_IPV4,
                   8'h45, 8'h00, ip_tot_len, ip_id, 16'h0000,
                   8'd64, cfg.ip_proto, csum, cfg.ip_src, cfg.ip_dst,
                   cfg.l4_src, cfg.l4_dst, udp_len, 16'h0000};

  always_comb begin
    hdr_bytes = '0;
    for (int k = 0; k < HDR_LEN; k++) begin
      hdr_bytes[8*k +: 8] = hdr_be[8*(HDR_LEN-1-k) +: 8];
    end
  end

endmodule

// File: rtl/pkt_gen_250.sv
// Synthetic Ethernet/IPv4/UDP frame generator driving a 512-bit AXI-stream
// master; runs are started, counted and stopped from static config inputs.
module pkt_gen_250
  import pkt_gen_pkg::*;
#(
  parameter int          DATA_WIDTH = 512,
  parameter int          KEEP_WIDTH = 64,
  parameter logic [15:0] TUSER_SRC  = 16'h0000,
  parameter logic [15:0] TUSER_DST  = 16'h0000
) (
  input  logic                  axis_aclk,
  input  logic                  box_rst,
  input  logic                  cfg_start,
  input  logic                  cfg_stop,
  input  logic [31:0]           cfg_count,
  input  logic [15:0]           cfg_pkt_len,
  input  logic [15:0]           cfg_gap,
  input  logic [47:0]           cfg_mac_dst,
  input  logic [47:0]           cfg_mac_src,
  input  logic [31:0]           cfg_ip_src,
  input  logic [31:0]           cfg_ip_dst,
  input  logic [15:0]           cfg_l4_src,
  input  logic [15:0]           cfg_l4_dst,
  input  logic [7:0]            cfg_ip_proto,
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic [15:0]           m_axis_tuser_size,
  output logic [15:0]           m_axis_tuser_src,
  output logic [15:0]           m_axis_tuser_dst,
  input  logic                  m_axis_tready,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           pkt_sent
);

  state_t   state;
  hdr_cfg_t cfg_live;
  hdr_cfg_t cfg_snap;
  hdr_cfg_t hdr_cfg;

  logic [15:0] len_snap;
  logic [15:0] gap_snap;
  logic [31:0] count_snap;
  logic [15:0] gap_cnt;
  logic [15:0] ip_id;
  logic [7:0]  beat_idx;
  logic        stop_pend;

  logic [15:0]           live_len;
  logic [15:0]           gen_len;
  logic [15:0]           gen_id;
  logic [7:0]            gen_beat;
  logic [15:0]           beat_base;
  logic [15:0]           byte_idx;
  logic [HDR_LEN*8-1:0]  hdr_bytes;
  logic [DATA_WIDTH-1:0] hdr_full;
  logic [DATA_WIDTH-1:0] gen_data;
  logic [KEEP_WIDTH-1:0] gen_keep;
  logic                  gen_last;

  logic stop_now;
  logic run_over;
  logic frame_end;
  logic load_out;
  logic clear_out;

  assign cfg_live.mac_dst  = cfg_mac_dst;
  assign cfg_live.mac_src  = cfg_mac_src;
  assign cfg_live.ip_src   = cfg_ip_src;
  assign cfg_live.ip_dst   = cfg_ip_dst;
  assign cfg_live.l4_src   = cfg_l4_src;
  assign cfg_live.l4_dst   = cfg_l4_dst;
  assign cfg_live.ip_proto = cfg_ip_proto;

  assign live_len = clamp_len(cfg_pkt_len);

  // In IDLE the first beat is built straight from the live config so it can
  // be registered in the same edge that accepts cfg_start.
  assign hdr_cfg  = (state == IDLE) ? cfg_live : cfg_snap;
  assign gen_len  = (state == IDLE) ? live_len : len_snap;
  assign gen_beat = (state == FRAME && !m_axis_tlast) ? beat_idx : 8'd0;
  assign gen_id   = (state == IDLE) ? 16'h0000 :
                    (state == FRAME && m_axis_tlast) ? ip_id + 16'd1 : ip_id;

  pkt_gen_hdr u_hdr (
    .cfg       (hdr_cfg),
    .ip_id     (gen_id),
    .len       (gen_len),
    .hdr_bytes (hdr_bytes)
  );

  assign hdr_full  = DATA_WIDTH'(hdr_bytes);
  assign beat_base = {2'b00, gen_beat, 6'b000000};
  assign gen_last  = (beat_base + 16'd64) >= gen_len;

  always_comb begin
    gen_data = '0;
    gen_keep = '0;
    byte_idx = '0;
    for (int j = 0; j < KEEP_WIDTH; j++) begin
      byte_idx = beat_base + 16'(j);
      if (byte_idx < gen_len) begin
        gen_keep[j] = 1'b1;
        if (byte_idx < 16'(HDR_LEN)) begin
          gen_data[8*j +: 8] = hdr_full[8*j +: 8];
        end else begin
          gen_data[8*j +: 8] = byte_idx[7:0] ^ gen_id[7:0];
        end
      end
    end
  end

  // tvalid is held high for the whole FRAME state, so tready alone marks a handshake there.
  assign stop_now  = stop_pend | cfg_stop;
  assign run_over  = ((count_snap != 32'd0) && (pkt_sent + 32'd1 == count_snap)) || stop_now;
  assign frame_end = (state == FRAME) && m_axis_tready && m_axis_tlast;

  assign load_out  = ((state == IDLE) && cfg_start) ||
                     ((state == FRAME) && m_axis_tready &&
                      !(m_axis_tlast && (run_over || gap_snap != 16'd0))) ||
                     ((state == GAP) && !stop_now && gap_cnt == 16'd0);
  assign clear_out = frame_end && (run_over || gap_snap != 16'd0);

  always_ff @(posedge axis_aclk or posedge box_rst) begin
    if (box_rst) begin
      m_axis_tvalid     <= 1'b0;
      m_axis_tdata      <= '0;
      m_axis_tkeep      <= '0;
      m_axis_tlast      <= 1'b0;
      m_axis_tuser_size <= '0;
      m_axis_tuser_src  <= '0;
      m_axis_tuser_dst  <= '0;
      beat_idx          <= '0;
    end else if (load_out) begin
      m_axis_tvalid     <= 1'b1;
      m_axis_tdata      <= gen_data;
      m_axis_tkeep      <= gen_keep;
      m_axis_tlast      <= gen_last;
      m_axis_tuser_size <= gen_len;
      m_axis_tuser_src  <= TUSER_SRC;
      m_axis_tuser_dst  <= TUSER_DST;
      beat_idx          <= gen_beat + 8'd1;
    end else if (clear_out) begin
      m_axis_tvalid     <= 1'b0;
      m_axis_tdata      <= '0;
      m_axis_tkeep      <= '0;
      m_axis_tlast      <= 1'b0;
      m_axis_tuser_size <= '0;
      m_axis_tuser_src  <= '0;
      m_axis_tuser_dst  <= '0;
      beat_idx          <= '0;
    end
  end

  always_ff @(posedge axis_aclk or posedge box_rst) begin
    if (box_rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      pkt_sent   <= '0;
      ip_id      <= '0;
      gap_cnt    <= '0;
      stop_pend  <= 1'b0;
      cfg_snap   <= '0;
      len_snap   <= '0;
      gap_snap   <= '0;
      count_snap <= '0;
    end else begin
      done <= 1'b0;
      if (busy && cfg_stop) begin
        stop_pend <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (cfg_start) begin
            state      <= FRAME;
            busy       <= 1'b1;
            cfg_snap   <= cfg_live;
            len_snap   <= live_len;
            gap_snap   <= cfg_gap;
            count_snap <= cfg_count;
            pkt_sent   <= '0;
            ip_id      <= '0;
            stop_pend  <= 1'b0;
          end
        end
        FRAME: begin
          if (frame_end) begin
            pkt_sent <= pkt_sent + 32'd1;
            ip_id    <= ip_id + 16'd1;
            if (run_over) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (gap_snap != 16'd0) begin
              state   <= GAP;
              gap_cnt <= gap_snap - 16'd1;
            end
          end
        end
        GAP: begin
          if (stop_now) begin
            state <= DONE;
            done  <= 1'b1;
          end else if (gap_cnt == 16'd0) begin
            state <= FRAME;
          end else begin
            gap_cnt <= gap_cnt - 16'd1;
          end
        end
        DONE: begin
          state     <= IDLE;
          busy      <= 1'b0;
          stop_pend <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
